// File: rtl/cr_kme_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cr_kme_fifo_pkg
// Helpers shared by the KME FIFO family.
//   ptr_inc    - advances a pointer in the range 0..depth-1 and wraps explicitly,
//                so depths that are not a power of two work.
//   fifo_ptr_w - pointer width needed to address depth entries (at least 1).
// -----------------------------------------------------------------------------
package cr_kme_fifo_pkg;

   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/cr_kme_pfifo_ctrl.sv
// -----------------------------------------------------------------------------
// cr_kme_pfifo_ctrl
// Control path of cr_kme_pfifo. It holds the read/write pointers and the
// occupancy counter. It qualifies the raw write/ack requests into wen/ren and
// registers the one-cycle overflow/underflow pulses.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_valid       - raw write request
//   i_ack         - raw pop request
//   i_clear       - synchronous flush (pointers and count to zero)
//   o_wen         - qualified write enable for the storage array
//   o_wptr/o_rptr - write/read pointers, 0..DEPTH-1
//   o_cnt         - registered occupancy
//   o_overflow    - pulse: a write was dropped in the previous cycle
//   o_underflow   - pulse: an ack arrived while empty in the previous cycle
// -----------------------------------------------------------------------------
module cr_kme_pfifo_ctrl
   import cr_kme_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic             i_ack,
   input  logic             i_clear,
   output logic             o_wen,
   output logic [PTR_W-1:0] o_wptr,
   output logic [PTR_W-1:0] o_rptr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_overflow,
   output logic             o_underflow
);

   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_empty;
   logic             w_full;
   logic             w_ren;
   logic             w_wen;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == CNT_W'(DEPTH));
   assign w_ren   = i_ack & ~w_empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_wen   = i_valid & (~w_full | w_ren);

   // The array write is suppressed during a flush or reset. The contents would
   // be unreachable anyway, but this keeps the discarded write truly discarded.
   assign o_wen   = w_wen & ~i_clear & ~rst;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, whatever the order of the statements.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_clear) begin
         // The flush wins over any request in the same cycle. That request is
         // not reported as an error.
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wen) r_wptr <= PTR_W'(ptr_inc(32'(r_wptr), DEPTH));
         if (w_ren) r_rptr <= PTR_W'(ptr_inc(32'(r_rptr), DEPTH));

         case ({w_wen, w_ren})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase

         r_overflow  <= i_valid & ~w_wen;
         r_underflow <= i_ack & w_empty;
      end
   end

   assign o_wptr      = r_wptr;
   assign o_rptr      = r_rptr;
   assign o_cnt       = r_cnt;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/cr_kme_pfifo.sv
// -----------------------------------------------------------------------------
// cr_kme_pfifo
// Parametrised first-word-fall-through FIFO. The producer side uses
// stall/valid and the consumer side uses valid/ack.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   fifo_in                - write data (WIDTH)
//   fifo_in_valid          - write request
//   fifo_in_stall          - early back-pressure: free_slots < STALL_THRESH
//   fifo_in_stall_override - forces fifo_in_stall low (full check still applies)
//   fifo_clear             - synchronous flush
//   fifo_out               - head entry, zero when empty (WIDTH)
//   fifo_out_valid         - FIFO non-empty
//   fifo_out_ack           - consumer pops the head
//   fifo_overflow          - pulse: a write was dropped
//   fifo_underflow         - pulse: an ack arrived while empty
//   used_slots/free_slots  - occupancy and remaining space (CNT_W)
// -----------------------------------------------------------------------------
module cr_kme_pfifo
   import cr_kme_fifo_pkg::*;
#(
   parameter int WIDTH        = 71,
   parameter int DEPTH        = 4,
   parameter int STALL_THRESH = 1,
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_in,
   input  logic             fifo_in_valid,
   output logic             fifo_in_stall,
   input  logic             fifo_in_stall_override,
   input  logic             fifo_clear,
   output logic [WIDTH-1:0] fifo_out,
   output logic             fifo_out_valid,
   input  logic             fifo_out_ack,
   output logic             fifo_overflow,
   output logic             fifo_underflow,
   output logic [CNT_W-1:0] used_slots,
   output logic [CNT_W-1:0] free_slots
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);

   // Elaboration-time legality checks on the parameters.
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "cr_kme_pfifo: WIDTH must be at least 1");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "cr_kme_pfifo: DEPTH must be at least 2");
   end
   if (STALL_THRESH < 1 || STALL_THRESH > DEPTH) begin : g_bad_thresh
      $fatal(1, "cr_kme_pfifo: STALL_THRESH must be in 1..DEPTH");
   end

   logic             w_wen;
   logic [PTR_W-1:0] w_wptr;
   logic [PTR_W-1:0] w_rptr;
   logic [CNT_W-1:0] w_cnt;
   logic             w_valid;
   logic [CNT_W-1:0] w_free;

   logic [WIDTH-1:0] r_mem [DEPTH];

   cr_kme_pfifo_ctrl #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .PTR_W (PTR_W)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (fifo_in_valid),
      .i_ack       (fifo_out_ack),
      .i_clear     (fifo_clear),
      .o_wen       (w_wen),
      .o_wptr      (w_wptr),
      .o_rptr      (w_rptr),
      .o_cnt       (w_cnt),
      .o_overflow  (fifo_overflow),
      .o_underflow (fifo_underflow)
   );

   // NOTE: the storage array has no reset. Stale entries are never visible
   // because fifo_out is masked to zero whenever the count says empty.
   always_ff @(posedge clk) begin
      if (w_wen) r_mem[w_wptr] <= fifo_in;
   end

   assign w_valid        = (w_cnt != '0);
   assign w_free         = CNT_W'(DEPTH) - w_cnt;

   assign fifo_out_valid = w_valid;
   assign fifo_out       = w_valid ? r_mem[w_rptr] : '0;
   assign used_slots     = w_cnt;
   assign free_slots     = w_free;

   // Stall depends only on the registered count, so it never forms a
   // combinational loop with the producer's valid or the consumer's ack.
   assign fifo_in_stall  = ~fifo_in_stall_override & (w_free < CNT_W'(STALL_THRESH));

endmodule

// File: tb/tb_cr_kme_pfifo.sv
// -----------------------------------------------------------------------------
// tb_cr_kme_pfifo
// Two instances: A (DEPTH=4, STALL_THRESH=1) and B (DEPTH=5, STALL_THRESH=2).
// Accepted writes push their data into a per-instance queue. A monitor on the
// falling edge pops the queue and compares it with fifo_out whenever a pop
// happens. Status outputs are checked directly against hand-derived values.
// -----------------------------------------------------------------------------
module tb_cr_kme_pfifo;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- instance A ----------------
   logic         a_rst = 1'b1, a_valid_in = 1'b0, a_ovr = 1'b0, a_clr = 1'b0, a_ack = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] a_out;
   logic         a_stall, a_valid, a_ovf, a_udf;
   logic [2:0]   a_used, a_free;

   cr_kme_pfifo #(.WIDTH(W), .DEPTH(4), .STALL_THRESH(1)) dut_a (
      .clk                    (clk),
      .rst                    (a_rst),
      .fifo_in                (a_in),
      .fifo_in_valid          (a_valid_in),
      .fifo_in_stall          (a_stall),
      .fifo_in_stall_override (a_ovr),
      .fifo_clear             (a_clr),
      .fifo_out               (a_out),
      .fifo_out_valid         (a_valid),
      .fifo_out_ack           (a_ack),
      .fifo_overflow          (a_ovf),
      .fifo_underflow         (a_udf),
      .used_slots             (a_used),
      .free_slots             (a_free)
   );

   // ---------------- instance B ----------------
   logic         b_rst = 1'b1, b_valid_in = 1'b0, b_ack = 1'b0;
   logic [W-1:0] b_in = '0;
   logic [W-1:0] b_out;
   logic         b_stall, b_valid, b_ovf, b_udf;
   logic [2:0]   b_used, b_free;

   cr_kme_pfifo #(.WIDTH(W), .DEPTH(5), .STALL_THRESH(2)) dut_b (
      .clk                    (clk),
      .rst                    (b_rst),
      .fifo_in                (b_in),
      .fifo_in_valid          (b_valid_in),
      .fifo_in_stall          (b_stall),
      .fifo_in_stall_override (1'b0),
      .fifo_clear             (1'b0),
      .fifo_out               (b_out),
      .fifo_out_valid         (b_valid),
      .fifo_out_ack           (b_ack),
      .fifo_overflow          (b_ovf),
      .fifo_underflow         (b_udf),
      .used_slots             (b_used),
      .free_slots             (b_free)
   );

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: a pop happens when ack meets valid outside flush/reset.
   always @(negedge clk) begin
      if (!a_rst && !a_clr && a_ack && a_valid) begin
         if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_pop_unexpected: got 0x%0h, expected no entry", a_out);
         end else begin
            check("a_pop_data", 32'(a_out), 32'(qa.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (!b_rst && b_ack && b_valid) begin
         if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_pop_unexpected: got 0x%0h, expected no entry", b_out);
         end else begin
            check("b_pop_data", 32'(b_out), 32'(qb.pop_front()));
         end
      end
   end

   // One cycle on A. The push flag records whether the write is expected to be accepted.
   task automatic cyc_a(input logic v, input logic [W-1:0] d, input logic ack,
                        input logic clr, input logic ovr, input logic push);
      a_valid_in = v; a_in = d; a_ack = ack; a_clr = clr; a_ovr = ovr;
      if (push) qa.push_back(d);
      @(posedge clk); #1;
   endtask

   task automatic idle_a();
      cyc_a(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic status_a(input string tag, input int used, input logic vld,
                           input logic stall, input logic ovf, input logic udf);
      check({tag, "_used"},  32'(a_used),  32'(used));
      check({tag, "_free"},  32'(a_free),  32'(4 - used));
      check({tag, "_valid"}, 32'(a_valid), 32'(vld));
      check({tag, "_stall"}, 32'(a_stall), 32'(stall));
      check({tag, "_ovf"},   32'(a_ovf),   32'(ovf));
      check({tag, "_udf"},   32'(a_udf),   32'(udf));
   endtask

   typedef struct {
      bit v;
      bit a;
      int cnt;
      bit stall;
   } step_t;

   // DEPTH=5, STALL_THRESH=2: 12 writes with interleaved acks. Stall is high while cnt >= 4.
   step_t tbl_b[19] = '{
      '{1, 0, 1, 0}, '{1, 0, 2, 0}, '{1, 0, 3, 0}, '{1, 0, 4, 1},
      '{1, 1, 4, 1}, '{1, 0, 5, 1}, '{1, 1, 5, 1}, '{0, 1, 4, 1},
      '{0, 1, 3, 0}, '{1, 1, 3, 0}, '{1, 0, 4, 1}, '{1, 0, 5, 1},
      '{1, 1, 5, 1}, '{1, 1, 5, 1}, '{0, 1, 4, 1}, '{0, 1, 3, 0},
      '{0, 1, 2, 0}, '{0, 1, 1, 0}, '{0, 1, 0, 0}
   };

   initial begin
      int wr_b;

      // ---------------- reset ----------------
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("a_rst_out", 32'(a_out), 32'h0);
      status_a("a_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("b_rst_free",  32'(b_free),  32'd5);
      check("b_rst_stall", 32'(b_stall), 32'd0);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // ---------------- A: fill 0x1..0x4 ----------------
      cyc_a(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a_fwft_out", 32'(a_out), 32'h01);
      status_a("a_w1", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc_a(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
      status_a("a_w3", 3, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc_a(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a_full_out", 32'(a_out), 32'h01);
      status_a("a_full", 4, 1'b1, 1'b1, 1'b0, 1'b0);

      // ---------------- A: write+ack while full ----------------
      cyc_a(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
      check("a_wr_full_ack_out", 32'(a_out), 32'h02);
      status_a("a_wr_full_ack", 4, 1'b1, 1'b1, 1'b0, 1'b0);

      // ---------------- A: override while full, write dropped ----------------
      a_valid_in = 1'b1; a_in = 8'h66; a_ack = 1'b0; a_ovr = 1'b1;
      #1;
      check("a_ovr_stall", 32'(a_stall), 32'd0);
      @(posedge clk); #1;
      check("a_drop_out", 32'(a_out), 32'h02);
      status_a("a_drop", 4, 1'b1, 1'b0, 1'b1, 1'b0);
      idle_a();
      status_a("a_drop_after", 4, 1'b1, 1'b1, 1'b0, 1'b0);

      // ---------------- A: drain (monitor checks 2,3,4,5) ----------------
      for (int i = 0; i < 4; i++) cyc_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("a_drained_out", 32'(a_out), 32'h0);
      status_a("a_drained", 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- A: ack on empty for 2 cycles ----------------
      cyc_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      status_a("a_udf1", 0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("a_udf2_out", 32'(a_out), 32'h0);
      status_a("a_udf2", 0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_a();
      status_a("a_udf_end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- A: clear with valid+ack on 3 entries ----------------
      cyc_a(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h0D, 1'b1, 1'b1, 1'b0, 1'b0);
      qa.delete();
      check("a_clr_out", 32'(a_out), 32'h0);
      status_a("a_clr", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_a(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a_post_clr_out", 32'(a_out), 32'h11);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // ---------------- A: reset mid-stream with valid+ack ----------------
      cyc_a(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_a(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1);
      a_rst = 1'b1;
      cyc_a(1'b1, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0);
      qa.delete();
      a_rst = 1'b0;
      check("a_rst_mid_out", 32'(a_out), 32'h0);
      status_a("a_rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_a(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a_post_rst_out", 32'(a_out), 32'h31);
      cyc_a(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_a();

      // ---------------- B: wrap with interleaved acks ----------------
      wr_b = 0;
      foreach (tbl_b[i]) begin
         b_valid_in = tbl_b[i].v;
         b_ack      = tbl_b[i].a;
         b_in       = 8'h40 + 8'(wr_b);
         if (tbl_b[i].v) begin
            qb.push_back(b_in);
            wr_b++;
         end
         @(posedge clk); #1;
         check($sformatf("b_step%0d_used", i),  32'(b_used),  32'(tbl_b[i].cnt));
         check($sformatf("b_step%0d_free", i),  32'(b_free),  32'(5 - tbl_b[i].cnt));
         check($sformatf("b_step%0d_stall", i), 32'(b_stall), 32'(tbl_b[i].stall));
         check($sformatf("b_step%0d_ovf", i),   32'(b_ovf),   32'd0);
      end
      b_valid_in = 1'b0;
      b_ack      = 1'b0;
      @(posedge clk); #1;
      check("b_end_valid", 32'(b_valid), 32'd0);

      // Every accepted write must have been popped and compared.
      check("a_queue_left", 32'(qa.size()), 32'd0);
      check("b_queue_left", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cr_kme_pfifo.md
# cr_kme_pfifo

Parametrised synchronous FIFO with a producer-side stall/valid interface and a consumer-side valid/ack interface. It replaces the fixed 71-bit, 4-entry KME FIFO wrappers. It adds configurable width, depth and stall threshold, a working stall override, a synchronous flush, and exported occupancy. It sits between KME pipeline stages wherever a small elastic buffer with early back-pressure is needed.

## Interface
Parameters:
- WIDTH, 71: data width in bits; must be at least 1.
- DEPTH, 4: number of entries; must be at least 2; need not be a power of two.
- STALL_THRESH, 1: `fifo_in_stall` asserts when free slots < STALL_THRESH; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1): derived width of the count outputs; not overridden by users.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fifo_in  in  WIDTH  write data.
- fifo_in_valid  in  1  write request.
- fifo_in_stall  out  1  back-pressure to producer.
- fifo_in_stall_override  in  1  forces `fifo_in_stall` to 0.
- fifo_clear  in  1  synchronous flush.
- fifo_out  out  WIDTH  head entry, first-word fall-through.
- fifo_out_valid  out  1  FIFO non-empty.
- fifo_out_ack  in  1  consumer pops the head.
- fifo_overflow  out  1  one-cycle pulse: a write was dropped.
- fifo_underflow  out  1  one-cycle pulse: an ack arrived while empty.
- used_slots  out  CNT_W  current occupancy.
- free_slots  out  CNT_W  DEPTH − used_slots.

## Operation
- Storage is a DEPTH×WIDTH register array. Read and write pointers run 0..DEPTH−1 and wrap explicitly at DEPTH−1, not by natural binary rollover.
- Occupancy is held in a registered counter `cnt`. `used_slots` = cnt. `free_slots` = DEPTH − cnt.
- ren = fifo_out_ack & (cnt != 0).
- wen = fifo_in_valid & ((cnt != DEPTH) | ren). A write to a full FIFO is accepted when a read happens in the same cycle.
- Dropped write: fifo_in_valid & !wen. Data is discarded, pointers are unchanged, and `fifo_overflow` pulses on the next cycle.
- Ack while empty: ignored, and `fifo_underflow` pulses on the next cycle.
- cnt update: +1 on wen only, −1 on ren only, unchanged when both or neither occur.
- fifo_out_valid = (cnt != 0). fifo_out = mem[rptr] when valid, otherwise all zeros.
- fifo_in_stall = !fifo_in_stall_override & (free_slots < STALL_THRESH). It is combinational from registered `cnt` only and has no path from `fifo_in_valid` or `fifo_out_ack`.
- Override does not bypass the full check. Writes beyond full are still dropped and reported as overflow.
- fifo_clear: on the next edge, pointers and cnt go to 0. Any wen/ren in the same cycle is discarded with no overflow or underflow pulse. Memory contents are not cleared.
- rst has priority over fifo_clear and has the same effect. In addition, the overflow/underflow pulse registers are reset.

## Timing
- Reset values: fifo_out_valid 0, fifo_out 0, used_slots 0, free_slots DEPTH, fifo_in_stall 0 (STALL_THRESH ≤ DEPTH guarantees this), fifo_overflow 0, fifo_underflow 0.
- Write-to-read latency: data written at edge N is visible on `fifo_out` with `fifo_out_valid`=1 after edge N. Empty-cycle pass-through is therefore 1 cycle.
- Pop: the ack is sampled at an edge; the next entry, or valid=0, is presented after that same edge.
- Stall responds one cycle after the occupancy change.
  - With STALL_THRESH = k, a producer that obeys stall can still issue writes in flight. No data is lost as long as k ≥ 1 and the producer honours stall with zero-cycle reaction.
- Error pulses are exactly one cycle wide per offending cycle. Consecutive bad cycles produce consecutive high cycles.
- Reset asserted mid-stream: the FIFO is empty on the cycle after the reset edge, regardless of inputs.

## Structure
- Package `cr_kme_fifo_pkg` holds two functions:
  - `ptr_inc(ptr, depth)` wrap helper.
  - a `clog2`-based width helper shared with other KME FIFOs.
- Parameter legality (DEPTH ≥ 2, 1 ≤ STALL_THRESH ≤ DEPTH) is checked by elaboration-time assertions in the top module.
- One sub-module, `cr_kme_pfifo_ctrl`, contains pointers, cnt, wen/ren qualification and error pulse registers. The top module holds the storage array, the output mux and the stall logic.

## Test plan
- Reset, then write 0x1..0x4 on consecutive cycles with DEPTH=4, STALL_THRESH=1, no ack: stall rises after the 4th write, used_slots=4, fifo_out=0x1, no overflow.
- Full FIFO with valid and ack in the same cycle: write is accepted, fifo_out advances to 0x2, cnt stays 4, fifo_overflow stays 0.
- Full FIFO with override=1 and valid=1, no ack: fifo_in_stall=0, data dropped, fifo_overflow pulses for 1 cycle, contents unchanged.
- Empty FIFO with ack=1 for 2 cycles: fifo_underflow is high for 2 cycles, cnt stays 0, fifo_out=0.
- DEPTH=5, STALL_THRESH=2: 12 writes with interleaved acks wrap the pointers; read order matches write order, and stall is high exactly while free_slots ≤ 1.
- fifo_clear asserted with valid and ack high on a 3-entry FIFO: next cycle used_slots=0, valid=0, no error pulses. rst asserted mid-stream gives identical results.
